lockstep_counter_checker: RTL and testbench

Synthesizable, race-free successor to the two-counter ordering check: per channel, a reference counter and a check counter advance on the same clock edge, and a registered compare stage counts any divergence. The design is parametrised in counter width, channel count and iteration count. It has a stall input, a fault-injection mask and a run/done handshake. It sits beside the regression harness as a self-checking lockstep monitor, and its `err_count` and `pass` outputs feed the harness status registers.

---
 rtl/lockstep_counter_checker.sv | 174 +++++++++++++++++
 tb/tb_lockstep_counter_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_counter_checker.sv
// lockstep_counter_checker
//
// Lockstep monitor. Each channel has a reference counter and a check counter
// that advance by (channel index + 1) on the same clock edge. A registered
// compare stage runs one edge after every step. It counts the compare cycles
// in which any channel disagrees, and keeps a sticky per-channel mismatch mask.
// A run has NUM_TESTS steps, followed by one DRAIN cycle for the last compare.
//
// Handshake: start_i is a request that is sampled only in IDLE or DONE, where
// it is accepted on the same edge; in RUN and DRAIN it is ignored. busy_o is
// high in RUN and DRAIN. done_o/pass_o are high in DONE, and all results hold
// there until the next accepted start_i or reset.
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          run request (IDLE/DONE only)
//   step_en_i        step enable in RUN (0 = stall)
//   inject_mask_i    per-channel suppression of the check increment on a step
//   busy_o           RUN or DRAIN
//   done_o           DONE
//   pass_o           DONE and no erroneous compare cycle
//   iter_o           completed steps in the current or last run
//   err_count_o      saturating count of compare cycles with any mismatch
//   mismatch_mask_o  sticky per-channel mismatch flags
//   ref_cnt_o        reference counters, channel c at [c*WIDTH +: WIDTH]
//   chk_cnt_o        check counters, same packing
//   state_o          current FSM state (debug observation)
module lockstep_counter_checker #(
  parameter int NUM_TESTS = 100,
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int ERR_WIDTH = 16,
  parameter int ITER_W    = $clog2(NUM_TESTS + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         step_en_i,
  input  logic [CHANNELS-1:0]          inject_mask_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [ITER_W-1:0]            iter_o,
  output logic [ERR_WIDTH-1:0]         err_count_o,
  output logic [CHANNELS-1:0]          mismatch_mask_o,
  output logic [CHANNELS*WIDTH-1:0]    ref_cnt_o,
  output logic [CHANNELS*WIDTH-1:0]    chk_cnt_o,
  output logic [1:0]                   state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ITER_W-1:0]    LAST_ITER = ITER_W'(NUM_TESTS);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX   = '1;

  state_e                      state_q;
  logic                        busy_q, done_q, pass_q;
  logic                        cmp_valid_q;
  logic [ITER_W-1:0]           iter_q;
  logic [ERR_WIDTH-1:0]        err_q, err_d;
  logic [CHANNELS-1:0]         mask_q, mask_d;
  logic [CHANNELS-1:0]         cmp_vec;
  logic [CHANNELS*WIDTH-1:0]   ref_q, ref_d;
  logic [CHANNELS*WIDTH-1:0]   chk_q, chk_d;

  // Counter values for a step edge. They are only loaded when a step occurs.
  // An injected channel keeps its check value, so the pair drifts apart.
  always_comb begin
    ref_d = ref_q;
    chk_d = chk_q;
    for (int c = 0; c < CHANNELS; c++) begin
      ref_d[c*WIDTH +: WIDTH] = ref_q[c*WIDTH +: WIDTH] + WIDTH'(c + 1);
      if (!inject_mask_i[c]) begin
        chk_d[c*WIDTH +: WIDTH] = chk_q[c*WIDTH +: WIDTH] + WIDTH'(c + 1);
      end
    end
  end

  // Compare stage. It works on the registered counters, so it always sees the
  // values from the step one edge earlier.
  always_comb begin
    cmp_vec = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cmp_vec[c] = (ref_q[c*WIDTH +: WIDTH] != chk_q[c*WIDTH +: WIDTH]);
    end
    mask_d = mask_q;
    err_d  = err_q;
    if (cmp_valid_q) begin
      mask_d = mask_q | cmp_vec;
      if ((|cmp_vec) && (err_q != ERR_MAX)) begin
        err_d = err_q + ERR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      iter_q      <= '0;
      err_q       <= '0;
      mask_q      <= '0;
      ref_q       <= '0;
      chk_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
            iter_q      <= '0;
            err_q       <= '0;
            mask_q      <= '0;
            ref_q       <= '0;
            chk_q       <= '0;
          end
        end
        S_RUN: begin
          mask_q <= mask_d;
          err_q  <= err_d;
          if (step_en_i) begin
            ref_q       <= ref_d;
            chk_q       <= chk_d;
            iter_q      <= iter_q + ITER_W'(1);
            cmp_valid_q <= 1'b1;
            if (iter_q + ITER_W'(1) == LAST_ITER) begin
              state_q <= S_DRAIN;
            end
          end else begin
            cmp_valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Compare the values from the final step and close the run.
          mask_q      <= mask_d;
          err_q       <= err_d;
          cmp_valid_q <= 1'b0;
          state_q     <= S_DONE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          pass_q      <= (err_d == '0);
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign iter_o          = iter_q;
  assign err_count_o     = err_q;
  assign mismatch_mask_o = mask_q;
  assign ref_cnt_o       = ref_q;
  assign chk_cnt_o       = chk_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_lockstep_counter_checker.sv
module tb_lockstep_counter_checker;
  localparam int NT = 100;
  localparam int CH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b, start_c;
  logic       step_en;
  logic [3:0] inject;

  // DUT A: default parameters
  logic        busy_a, done_a, pass_a;
  logic [6:0]  iter_a;
  logic [15:0] err_a;
  logic [3:0]  mask_a;
  logic [31:0] ref_a, chk_a;
  logic [1:0]  state_a;

  // DUT B: 4-bit error counter
  logic        busy_b, done_b, pass_b;
  logic [6:0]  iter_b;
  logic [3:0]  err_b;
  logic [3:0]  mask_b;
  logic [31:0] ref_b, chk_b;
  logic [1:0]  state_b;

  // DUT C: one test, one channel
  logic        busy_c, done_c, pass_c;
  logic [0:0]  iter_c;
  logic [15:0] err_c;
  logic [0:0]  mask_c;
  logic [7:0]  ref_c, chk_c;
  logic [1:0]  state_c;

  lockstep_counter_checker u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .step_en_i(step_en),
    .inject_mask_i(inject), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .iter_o(iter_a), .err_count_o(err_a), .mismatch_mask_o(mask_a),
    .ref_cnt_o(ref_a), .chk_cnt_o(chk_a), .state_o(state_a)
  );

  lockstep_counter_checker #(.ERR_WIDTH(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .step_en_i(step_en),
    .inject_mask_i(inject), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .iter_o(iter_b), .err_count_o(err_b), .mismatch_mask_o(mask_b),
    .ref_cnt_o(ref_b), .chk_cnt_o(chk_b), .state_o(state_b)
  );

  lockstep_counter_checker #(.NUM_TESTS(1), .CHANNELS(1)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .step_en_i(step_en),
    .inject_mask_i(inject[0]), .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c),
    .iter_o(iter_c), .err_count_o(err_c), .mismatch_mask_o(mask_c),
    .ref_cnt_o(ref_c), .chk_cnt_o(chk_c), .state_o(state_c)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Counter values follow from how many steps each counter has taken:
  // reference = (c+1)*steps, check = (c+1)*(steps - injected steps), mod 256.
  int       m_steps;
  int       m_inj [CH];
  int       m_err;
  int       m_stalls;
  logic [3:0] m_mask;
  bit       m_pending;
  bit       m_done;

  function automatic logic [31:0] model_vec(input bit use_chk);
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) begin
      int s;
      s = use_chk ? (m_steps - m_inj[c]) : m_steps;
      v[c*8 +: 8] = 8'(((c + 1) * s) % 256);
    end
    return v;
  endfunction

  function automatic logic [3:0] model_diff();
    logic [31:0] r, k;
    logic [3:0]  d;
    r = model_vec(1'b0);
    k = model_vec(1'b1);
    for (int c = 0; c < CH; c++) d[c] = (r[c*8 +: 8] != k[c*8 +: 8]);
    return d;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_ab(input string tag);
    check({tag, "_iter"},   iter_a, m_steps);
    check({tag, "_err"},    err_a,  sat(m_err, 65535));
    check({tag, "_mask"},   mask_a, m_mask);
    check({tag, "_busy"},   busy_a, !m_done);
    check({tag, "_done"},   done_a, m_done);
    check({tag, "_ref"},    ref_a,  model_vec(1'b0));
    check({tag, "_chk"},    chk_a,  model_vec(1'b1));
    check({tag, "_err_b"},  err_b,  sat(m_err, 15));
    check({tag, "_mask_b"}, mask_b, m_mask);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_flags"}, {busy_a, done_a, pass_a}, 3'b000);
    check({tag, "_a_iter"},  iter_a, 0);
    check({tag, "_a_err"},   err_a,  0);
    check({tag, "_a_mask"},  mask_a, 0);
    check({tag, "_a_ref"},   ref_a,  0);
    check({tag, "_a_chk"},   chk_a,  0);
    check({tag, "_b_all"},   {busy_b, done_b, pass_b, iter_b, err_b, mask_b, ref_b, chk_b}, 0);
    check({tag, "_c_all"},   {busy_c, done_c, pass_c, iter_c, err_c, mask_c, ref_c, chk_c}, 0);
  endtask

  // ---------------- driver: one run of DUT A (and B in parallel) ----------------
  // stall_mode: 0 always step, 1 step on odd edges, 2 random
  // inj_mode:   0 none, 1 ch2 on step 10, 2 ch0 on step 1, 3 random
  task automatic run_main(input int stall_mode, input int inj_mode, input int restart_at,
                          input int reset_at, output int done_edge);
    bit was_run, stepping;
    logic [3:0] diff;
    done_edge = -1;
    @(negedge clk);
    start_a = 1'b1; start_b = 1'b1; step_en = 1'b0; inject = '0;
    @(posedge clk);
    m_steps = 0; m_err = 0; m_mask = '0; m_pending = 1'b0; m_stalls = 0; m_done = 1'b0;
    for (int c = 0; c < CH; c++) m_inj[c] = 0;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    check_ab("start");
    for (int n = 1; n <= 2000 && !m_done; n++) begin
      was_run = (m_steps < NT);
      case (stall_mode)
        0:       step_en = 1'b1;
        1:       step_en = (n % 2 == 1);
        default: step_en = ($urandom_range(0, 3) != 0);
      endcase
      inject = '0;
      case (inj_mode)
        1: if (m_steps + 1 == 10) inject = 4'b0100;
        2: if (m_steps + 1 == 1)  inject = 4'b0001;
        3: if ($urandom_range(0, 9) == 0) inject = 4'($urandom_range(1, 15));
        default: inject = '0;
      endcase
      start_a = (restart_at >= 0 && m_steps == restart_at);
      @(posedge clk);
      if (m_pending) begin
        diff = model_diff();
        m_mask = m_mask | diff;
        if (diff != 0) m_err++;
      end
      stepping = was_run && step_en;
      if (stepping) begin
        m_steps++;
        for (int c = 0; c < CH; c++) if (inject[c]) m_inj[c]++;
      end else if (was_run) begin
        m_stalls++;
      end
      m_pending = stepping;
      if (!was_run) begin
        m_done = 1'b1;
        done_edge = n;
      end
      @(negedge clk);
      start_a = 1'b0;
      check_ab("run");
      if (reset_at >= 0 && m_steps == reset_at && !m_done) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    check("run_completed", m_done, 1'b1);
    check("pass_a", pass_a, (m_err == 0));
    check("pass_b", pass_b, (m_err == 0));
    check("latency", done_edge, NT + 1 + m_stalls);
    // Results hold in DONE whatever the other inputs do.
    for (int h = 0; h < 3; h++) begin
      step_en = 1'($urandom_range(0, 1));
      inject  = 4'($urandom_range(0, 15));
      @(negedge clk);
      check_ab("hold");
      check("hold_pass", pass_a, (m_err == 0));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int de;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    step_en = 1'b0; inject = '0;
    #22;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // One-test, one-channel instance: busy for two cycles, done at E2.
    @(negedge clk);
    start_c = 1'b1; step_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_c = 1'b0;
    check("c_e0", {busy_c, done_c, iter_c}, 3'b100);
    @(negedge clk);
    check("c_e1", {busy_c, done_c, iter_c, ref_c}, {3'b101, 8'd1});
    @(negedge clk);
    check("c_e2_flags", {busy_c, done_c, pass_c}, 3'b011);
    check("c_e2_cnt", {iter_c, ref_c, chk_c, err_c, mask_c}, {1'b1, 8'd1, 8'd1, 16'd0, 1'b0});

    // Clean run.
    run_main(0, 0, -1, -1, de);
    check("s1_ref", ref_a, {8'd144, 8'd44, 8'd200, 8'd100});
    check("s1_chk", chk_a, {8'd144, 8'd44, 8'd200, 8'd100});
    check("s1_done_edge", de, 101);
    check("s1_res", {pass_a, iter_a, err_a}, {1'b1, 7'd100, 16'd0});

    // Single injection on channel 2 at step 10.
    run_main(0, 1, -1, -1, de);
    check("s2_chk2", chk_a[23:16], 8'd41);
    check("s2_res", {pass_a, mask_a, err_a}, {1'b0, 4'b0100, 16'd91});

    // Step enable toggled every cycle.
    run_main(1, 0, -1, -1, de);
    check("s3_done_edge", de, 200);
    check("s3_ref", ref_a, {8'd144, 8'd44, 8'd200, 8'd100});
    check("s3_res", {pass_a, iter_a, err_a}, {1'b1, 7'd100, 16'd0});

    // Start pulsed mid-run is ignored.
    run_main(0, 0, 30, -1, de);
    check("s4_done_edge", de, 101);
    check("s4_ref", ref_a, {8'd144, 8'd44, 8'd200, 8'd100});

    // Reset mid-run, then a clean run.
    run_main(0, 0, -1, 50, de);
    run_main(0, 0, -1, -1, de);
    check("s4b_ref", ref_a, {8'd144, 8'd44, 8'd200, 8'd100});
    check("s4b_res", {pass_a, iter_a, err_a}, {1'b1, 7'd100, 16'd0});

    // Injection at step 1: the small counter saturates.
    run_main(0, 2, -1, -1, de);
    check("s5_err_b", err_b, 4'd15);
    check("s5_b_res", {pass_b, mask_b}, {1'b0, 4'b0001});
    check("s5_err_a", err_a, 16'd100);

    // Randomized runs.
    for (int r = 0; r < 4; r++) run_main(2, 3, -1, -1, de);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
